// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - CPU load/store port and backing-memory bus of the data cache
interface dcache_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     cpu_re;
  logic                     cpu_we;
  logic                     byte_op;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_wdata;
  logic [DATA_WIDTH-1:0]    cpu_rdata;
  logic                     stall;
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     mem_ack;
  logic [31:0]              hit_count;
  logic [31:0]              miss_count;

  // Controller view.
  modport slave (
    input  cpu_re, cpu_we, byte_op, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );

  // CPU and backing-memory view.
  modport master (
    output cpu_re, cpu_we, byte_op, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CACHE_SIZE    = 64
) (
  input logic           clk,
  input logic           rst,
  dcache_ctrl_if.slave  bus
);
  localparam int INDEX_BITS = $clog2(CACHE_SIZE);
  localparam int TAG_BITS   = ADDRESS_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {LOOKUP, WRITEBACK, REFILL} state_t;

  state_t                   state_q, state_d;
  logic [CACHE_SIZE-1:0]    valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_BITS-1:0]      tag_q  [CACHE_SIZE];
  logic [TAG_BITS-1:0]      tag_d  [CACHE_SIZE];
  logic [DATA_WIDTH-1:0]    data_q [CACHE_SIZE];
  logic [DATA_WIDTH-1:0]    data_d [CACHE_SIZE];
  logic                     mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [31:0]              hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic                     retry_q, retry_d;

  logic                     access, hit, ack;
  logic [1:0]               offset;
  logic [INDEX_BITS-1:0]    index;
  logic [TAG_BITS-1:0]      tag;
  logic [DATA_WIDTH-1:0]    line, load_data, store_word;

  always_comb begin
    access = bus.cpu_re | bus.cpu_we;
    offset = bus.cpu_addr[1:0];
    index  = bus.cpu_addr[INDEX_BITS+1:2];
    tag    = bus.cpu_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];
    line   = data_q[index];
    hit    = valid_q[index] & (tag_q[index] == tag);
    ack    = bus.mem_ack & mem_req_q;
    // Big-endian lanes: byte offset 0 lives in bits 31:24.
    load_data  = line;
    store_word = bus.cpu_wdata;
    if (bus.byte_op) begin
      case (offset)
        2'd0: begin
          load_data  = {24'd0, line[31:24]};
          store_word = {bus.cpu_wdata[7:0], line[23:0]};
        end
        2'd1: begin
          load_data  = {24'd0, line[23:16]};
          store_word = {line[31:24], bus.cpu_wdata[7:0], line[15:0]};
        end
        2'd2: begin
          load_data  = {24'd0, line[15:8]};
          store_word = {line[31:16], bus.cpu_wdata[7:0], line[7:0]};
        end
        default: begin
          load_data  = {24'd0, line[7:0]};
          store_word = {line[31:8], bus.cpu_wdata[7:0]};
        end
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    retry_d      = 1'b0;
    case (state_q)
      LOOKUP: begin
        if (access && hit) begin
          if (bus.cpu_we) begin
            data_d[index]  = store_word;
            dirty_d[index] = 1'b1;
          end
          // The retry after a refill completes an access already counted as a miss.
          if (!retry_q && hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
        end else if (access) begin
          if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
          mem_req_d = 1'b1;
          if (valid_q[index] && dirty_q[index]) begin
            state_d     = WRITEBACK;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[index], index, 2'b00};
            mem_wdata_d = line;
          end else begin
            state_d    = REFILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag, index, 2'b00};
          end
        end
      end
      WRITEBACK: begin
        if (ack) begin
          state_d   = REFILL;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      REFILL: begin
        // Arriving from WRITEBACK, mem_req is low for one gap cycle before the read starts.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {tag, index, 2'b00};
        end else if (ack) begin
          data_d[index]  = bus.mem_rdata;
          tag_d[index]   = tag;
          valid_d[index] = 1'b1;
          dirty_d[index] = 1'b0;
          mem_req_d      = 1'b0;
          state_d        = LOOKUP;
          retry_d        = 1'b1;
        end
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOOKUP;
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      retry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      retry_q      <= retry_d;
    end
  end

  assign bus.stall      = access & ((state_q != LOOKUP) | !hit);
  assign bus.cpu_rdata  = hit ? load_data : '0;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store port and the word-wide backing data memory.
- Holds CACHE_SIZE one-word lines (tag/valid/dirty/data) internally.
- Hits return data combinationally with no stall. Misses stall the CPU while the controller sequences an optional writeback and then a refill over a req/ack handshake.
- Byte ops use big-endian byte lanes: byte offset 0 is bits 31:24.

Parameters:
- ADDRESS_WIDTH, 32, CPU/memory byte-address width.
- DATA_WIDTH, 32, word width (fixed at 32 for byte-lane logic).
- CACHE_SIZE, 64, number of lines; power of two. INDEX_BITS = log2(CACHE_SIZE).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_re  in  1  load request.
- cpu_we  in  1  store request; has priority over cpu_re when both are high.
- byte_op  in  1  1 = byte access, 0 = word access (address[1:0] ignored).
- cpu_addr  in  ADDRESS_WIDTH  byte address.
- cpu_wdata  in  DATA_WIDTH  store data; byte stores use [7:0].
- cpu_rdata  out  DATA_WIDTH  load data: word, or byte zero-extended into [7:0].
- stall  out  1  CPU must hold all cpu_* inputs while high.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = write (writeback), 0 = read (refill).
- mem_addr  out  ADDRESS_WIDTH  word-aligned address ([1:0]=0).
- mem_wdata  out  DATA_WIDTH  writeback data.
- mem_rdata  in  DATA_WIDTH  refill data, valid when mem_ack=1.
- mem_ack  in  1  one-cycle completion pulse for the outstanding request.
- hit_count  out  32  accesses that hit on first lookup; saturates at 0xFFFFFFFF.
- miss_count  out  32  accesses that missed; saturates at 0xFFFFFFFF.

Behaviour:

Address split:
- offset = addr[1:0]
- index = addr[INDEX_BITS+1:2]
- tag = addr[ADDRESS_WIDTH-1:INDEX_BITS+2]

Hit and stall (combinational):
- access = cpu_re | cpu_we.
- hit = valid[index] & (tag_mem[index] == tag).
- stall = access & (state != LOOKUP | !hit).

Reset:
- Applies on the clk edge where rst=1.
- state = LOOKUP; all valid and dirty bits = 0; mem_req = 0; mem_we = 0; hit_count = 0; miss_count = 0.
- cpu_rdata = 0 while no hit.
- A reset mid-transaction abandons it: mem_req is 0 from the next cycle, late mem_ack is ignored, and dirty data is lost.

FSM states:
- LOOKUP
  - access & hit, load: cpu_rdata = selected word or byte; stall = 0.
  - access & hit, store: at the edge, write the word, or the byte into lane (3-offset)*8; set dirty = 1; stall = 0.
  - access & !hit: count the miss; go to WRITEBACK if valid & dirty, else REFILL.
- WRITEBACK
  - mem_req = 1, mem_we = 1, mem_addr = {tag_mem[index], index, 2'b00}, mem_wdata = line data.
  - On mem_ack: go to REFILL.
- REFILL
  - mem_req = 1, mem_we = 0, mem_addr = {tag, index, 2'b00}.
  - On mem_ack: line = mem_rdata, tag stored, valid = 1, dirty = 0; go to LOOKUP.
  - The next cycle is a hit and completes the access (stores merge then).

Handshake and timing:
- mem_req, mem_we, mem_addr and mem_wdata are registered and held stable from the cycle after the decision until the ack cycle.
- mem_req deasserts the cycle after ack. Back-to-back WRITEBACK→REFILL has one mem_req=0 gap cycle.
- mem_ack while mem_req=0 is ignored.
- Clean-miss latency = 1 (lookup) + mem cycles until ack + 1 (retry). Dirty miss adds the writeback duration + 1.

Counters:
- hit_count increments on an access in LOOKUP with hit, excluding the retry cycle after a refill.
- miss_count increments once per miss, on entry from LOOKUP.

Edge cases:
- No access: the FSM stays in LOOKUP and counters hold.
- Addresses differing only in [1:0] share a line.

Test Plan:
1. Reset, then word load addr 0x00000100; mem_ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0; stall high until the retry cycle; cpu_rdata=0xDEADBEEF; miss_count=1, hit_count=0.
2. Then byte load 0x102 -> no stall, cpu_rdata=0x000000BE, hit_count=1.
3. Byte store 0xAA to 0x101, then word load 0x100 -> cpu_rdata=0xDEAABEEF, no stall, line dirty.
4. Word load 0x00000200 (same index, new tag) -> WRITEBACK with mem_we=1, mem_addr=0x100, mem_wdata=0xDEAABEEF; then REFILL with mem_addr=0x200; miss_count=2.
5. cpu_we and cpu_re both high on a hit -> store performed, load ignored. With no access for 10 cycles, counters and mem_req are unchanged.
6. Assert rst during REFILL, then pulse mem_ack after reset -> mem_req=0, access to 0x200 misses again, counters read 0 before that access.
